// File: rtl/tone_gen_if.sv
// rtl/tone_gen_if.sv - note/volume request and tone status bundle for tone_gen
interface tone_gen_if;
  logic [4:0] note;
  logic [1:0] vol;
  logic       speaker;
  logic       active;
  logic       note_ack;

  // Sequencer / keyboard side drives the note request and watches the status.
  modport master (
    output note,
    output vol,
    input  speaker,
    input  active,
    input  note_ack
  );

  // Tone generator side.
  modport slave (
    input  note,
    input  vol,
    output speaker,
    output active,
    output note_ack
  );
endinterface

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - note code to glitch-free square wave, optional volume via TONE_GEN_VOLUME_EN
module tone_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input logic      clk,
  input logic      rst,
  tone_gen_if.slave bus
);

  localparam int NOTES = 22;

  function automatic int freq_of(input int n);
    case (n)
      1:  return 131;
      2:  return 147;
      3:  return 165;
      4:  return 175;
      5:  return 196;
      6:  return 220;
      7:  return 247;
      8:  return 262;
      9:  return 294;
      10: return 330;
      11: return 349;
      12: return 392;
      13: return 440;
      14: return 494;
      15: return 523;
      16: return 587;
      17: return 659;
      18: return 698;
      19: return 784;
      20: return 880;
      21: return 988;
      default: return 1;
    endcase
  endfunction

  // Half-period table, folded at elaboration; entry 0 (rest) is never used.
  function automatic logic [NOTES*20-1:0] build_half_rom();
    logic [NOTES*20-1:0] rom;
    rom = '0;
    for (int i = 1; i < NOTES; i++) begin
      rom[i*20 +: 20] = 20'(CLK_HZ / (2 * freq_of(i)));
    end
    return rom;
  endfunction

  localparam logic [NOTES*20-1:0] HALF_ROM = build_half_rom();

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_d;
  logic [4:0]  note_q, note_d;
  logic [19:0] half_q, half_d;
  logic [19:0] low_half_q, low_half_d;
  logic [19:0] cnt, cnt_d;
  logic        phase, phase_d;
  logic        speaker_q, speaker_d;
  logic        ack_q, ack_d;
  logic        note_valid;
  logic [19:0] half_new;
  logic [19:0] cur_half;

`ifdef TONE_GEN_VOLUME_EN
  logic [19:0] thr_q, thr_d;

  function automatic logic [19:0] thr_of(input logic [1:0] v, input logic [19:0] h);
    case (v)
      2'd3:    return h;
      2'd2:    return h >> 1;
      2'd1:    return h >> 2;
      default: return '0;
    endcase
  endfunction
`else
  logic unused_vol;
  assign unused_vol = ^bus.vol;
`endif

  // Decode the incoming note code into a validity flag and its half period.
  always_comb begin
    note_valid = (bus.note >= 5'd1) && (bus.note <= 5'd21);
    half_new   = '0;
    if (note_valid) half_new = HALF_ROM[32'(bus.note)*20 +: 20];
  end

  // Next-state logic: latch in IDLE, count and toggle in RUN, sample note only at falling edges.
  always_comb begin
    state_d    = state;
    note_d     = note_q;
    half_d     = half_q;
    low_half_d = low_half_q;
    cnt_d      = cnt;
    phase_d    = phase;
    ack_d      = 1'b0;
`ifdef TONE_GEN_VOLUME_EN
    thr_d      = thr_q;
`endif
    // The low phase keeps the pitch of the high phase before it, so every period is whole.
    cur_half   = phase ? half_q : low_half_q;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (note_valid) begin
          note_d  = bus.note;
          half_d  = half_new;
          ack_d   = 1'b1;
          phase_d = 1'b1;
          state_d = RUN;
`ifdef TONE_GEN_VOLUME_EN
          thr_d   = thr_of(bus.vol, half_new);
`endif
        end
      end
      RUN: begin
        if (cnt == cur_half - 20'd1) begin
          cnt_d   = '0;
          phase_d = ~phase;
          if (phase) begin
            low_half_d = half_q;
            if (!note_valid) begin
              state_d = IDLE;
              phase_d = 1'b0;
            end else if (bus.note != note_q) begin
              note_d = bus.note;
              half_d = half_new;
              ack_d  = 1'b1;
`ifdef TONE_GEN_VOLUME_EN
              thr_d  = thr_of(bus.vol, half_new);
            end else begin
              thr_d  = thr_of(bus.vol, half_q);
`endif
            end
          end
        end else begin
          cnt_d = cnt + 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TONE_GEN_VOLUME_EN
    speaker_d = phase_d && (cnt_d < thr_d);
`else
    speaker_d = phase_d;
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      note_q     <= '0;
      half_q     <= '0;
      low_half_q <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      speaker_q  <= 1'b0;
      ack_q      <= 1'b0;
`ifdef TONE_GEN_VOLUME_EN
      thr_q      <= '0;
`endif
    end else begin
      state      <= state_d;
      note_q     <= note_d;
      half_q     <= half_d;
      low_half_q <= low_half_d;
      cnt        <= cnt_d;
      phase      <= phase_d;
      speaker_q  <= speaker_d;
      ack_q      <= ack_d;
`ifdef TONE_GEN_VOLUME_EN
      thr_q      <= thr_d;
`endif
    end
  end

  assign bus.speaker  = speaker_q;
  assign bus.note_ack = ack_q;
  assign bus.active   = (state == RUN);

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - directed self-checking bench for tone_gen
module tb_tone_gen;

  localparam int CLK_HZ    = 1_048_000;
  localparam int RUN_LIMIT = 10_000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   ack_cnt;
  int   ack_double;
  logic ack_prev;

  tone_gen_if bus ();

  tone_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Advance one cycle and sample at the falling clock edge, tracking note_ack pulses.
  task automatic tick();
    @(negedge clk);
    if (bus.note_ack === 1'b1) begin
      if (ack_prev) ack_double++;
      ack_cnt++;
    end
    ack_prev = bus.note_ack;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.note = 5'd0;
    bus.vol  = 2'd3;
    tick();
    tick();
    rst        = 1'b0;
    ack_cnt    = 0;
    ack_double = 0;
    ack_prev   = 1'b0;
  endtask

  // Count consecutive samples at the given speaker level; optionally change note partway.
  task automatic measure_run(input logic level, input int switch_at,
                             input logic [4:0] switch_note, output int len);
    len = 0;
    while (bus.speaker === level && len < RUN_LIMIT) begin
      len++;
      if (len == switch_at) bus.note = switch_note;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.speaker !== 1'b0) begin
      errors++; $display("FAIL reset_speaker: got %b, expected 0", bus.speaker);
    end
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL reset_active: got %b, expected 0", bus.active);
    end
    checks++;
    if (bus.note_ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b, expected 0", bus.note_ack);
    end
  endtask

  task automatic test_note_start();
    int len;
    do_reset();
    bus.note = 5'd8;
    tick();
    checks++;
    if (bus.note_ack !== 1'b1) begin
      errors++; $display("FAIL start_ack: got %b, expected 1", bus.note_ack);
    end
    checks++;
    if (bus.speaker !== 1'b1) begin
      errors++; $display("FAIL start_speaker: got %b, expected 1", bus.speaker);
    end
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL start_active: got %b, expected 1", bus.active);
    end
    measure_run(1'b1, 0, 5'd0, len);
    checks++;
    if (len !== 2000) begin
      errors++; $display("FAIL start_high1: got %0d cycles, expected 2000", len);
    end
    checks++;
    if (bus.note_ack !== 1'b0) begin
      errors++; $display("FAIL start_same_note_ack: got %b, expected 0", bus.note_ack);
    end
    measure_run(1'b0, 0, 5'd0, len);
    checks++;
    if (len !== 2000) begin
      errors++; $display("FAIL start_low1: got %0d cycles, expected 2000", len);
    end
    measure_run(1'b1, 0, 5'd0, len);
    checks++;
    if (len !== 2000) begin
      errors++; $display("FAIL start_high2: got %0d cycles, expected 2000", len);
    end
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL start_active_run: got %b, expected 1", bus.active);
    end
  endtask

  task automatic test_pitch_change();
    int len;
    do_reset();
    bus.note = 5'd8;
    tick();
    ack_cnt = 0;
    measure_run(1'b1, 1000, 5'd13, len);
    checks++;
    if (len !== 2000) begin
      errors++; $display("FAIL pitch_high_old: got %0d cycles, expected 2000", len);
    end
    checks++;
    if (bus.note_ack !== 1'b1) begin
      errors++; $display("FAIL pitch_ack_at_fall: got %b, expected 1", bus.note_ack);
    end
    measure_run(1'b0, 0, 5'd0, len);
    checks++;
    if (len !== 2000) begin
      errors++; $display("FAIL pitch_low_old: got %0d cycles, expected 2000", len);
    end
    measure_run(1'b1, 0, 5'd0, len);
    checks++;
    if (len !== 1190) begin
      errors++; $display("FAIL pitch_high_new: got %0d cycles, expected 1190", len);
    end
    measure_run(1'b0, 0, 5'd0, len);
    checks++;
    if (len !== 1190) begin
      errors++; $display("FAIL pitch_low_new: got %0d cycles, expected 1190", len);
    end
    checks++;
    if (ack_cnt !== 1) begin
      errors++; $display("FAIL pitch_ack_count: got %0d, expected 1", ack_cnt);
    end
  endtask

  task automatic test_stop();
    int len;
    int highs;
    do_reset();
    bus.note = 5'd8;
    tick();
    measure_run(1'b1, 700, 5'd0, len);
    checks++;
    if (len !== 2000) begin
      errors++; $display("FAIL stop_last_high: got %0d cycles, expected 2000", len);
    end
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL stop_active_drop: got %b, expected 0", bus.active);
    end
    highs = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.speaker !== 1'b0 || bus.active !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++; $display("FAIL stop_stays_silent: got %0d busy cycles, expected 0", highs);
    end
  endtask

  task automatic test_invalid_and_reset();
    int busy;
    int len;
    do_reset();
    bus.note = 5'd25;
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.speaker !== 1'b0 || bus.active !== 1'b0) busy++;
    end
    bus.note = 5'd22;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.speaker !== 1'b0 || bus.active !== 1'b0) busy++;
    end
    checks++;
    if (busy !== 0) begin
      errors++; $display("FAIL invalid_silent: got %0d busy cycles, expected 0", busy);
    end
    checks++;
    if (ack_cnt !== 0) begin
      errors++; $display("FAIL invalid_no_ack: got %0d acks, expected 0", ack_cnt);
    end
    bus.note = 5'd21;
    tick();
    checks++;
    if (bus.note_ack !== 1'b1) begin
      errors++; $display("FAIL note21_ack: got %b, expected 1", bus.note_ack);
    end
    measure_run(1'b1, 0, 5'd0, len);
    checks++;
    if (len !== 530) begin
      errors++; $display("FAIL note21_high: got %0d cycles, expected 530", len);
    end
    bus.note = 5'd8;
    for (int i = 0; i < 300; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.speaker !== 1'b0 || bus.active !== 1'b0 || bus.note_ack !== 1'b0) begin
      errors++;
      $display("FAIL midtone_reset: got spk=%b act=%b ack=%b, expected 0 0 0",
               bus.speaker, bus.active, bus.note_ack);
    end
    rst = 1'b0;
    bus.note = 5'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    int len;
    do_reset();
    bus.note = 5'd8;
    tick();
    for (int p = 0; p < 10; p++) begin
      measure_run(1'b1, 0, 5'd0, len);
      checks++;
      if (len !== 2000) begin
        errors++; $display("FAIL hold_high[%0d]: got %0d cycles, expected 2000", p, len);
      end
      measure_run(1'b0, 0, 5'd0, len);
      checks++;
      if (len !== 2000) begin
        errors++; $display("FAIL hold_low[%0d]: got %0d cycles, expected 2000", p, len);
      end
    end
    checks++;
    if (ack_cnt !== 1) begin
      errors++; $display("FAIL hold_ack_count: got %0d, expected 1", ack_cnt);
    end
    checks++;
    if (ack_double !== 0) begin
      errors++; $display("FAIL hold_ack_consecutive: got %0d, expected 0", ack_double);
    end
  endtask

`ifdef TONE_GEN_VOLUME_EN
  task automatic test_volume();
    int len;
    int highs;
    do_reset();
    bus.vol  = 2'd2;
    bus.note = 5'd8;
    tick();
    measure_run(1'b1, 0, 5'd0, len);
    checks++;
    if (len !== 1000) begin
      errors++; $display("FAIL vol2_high: got %0d cycles, expected 1000", len);
    end
    measure_run(1'b0, 0, 5'd0, len);
    checks++;
    if (len !== 3000) begin
      errors++; $display("FAIL vol2_low: got %0d cycles, expected 3000", len);
    end
    do_reset();
    bus.vol  = 2'd0;
    bus.note = 5'd8;
    highs = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (bus.speaker !== 1'b0 || bus.active !== 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++; $display("FAIL vol0_mute: got %0d bad cycles, expected 0", highs);
    end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    ack_cnt    = 0;
    ack_double = 0;
    ack_prev   = 1'b0;
    rst        = 1'b1;
    bus.note   = 5'd0;
    bus.vol    = 2'd3;
    test_reset();
    test_note_start();
    test_pitch_change();
    test_stop();
    test_invalid_and_reset();
    test_back_to_back();
`ifdef TONE_GEN_VOLUME_EN
    test_volume();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
